// File: rtl/datamem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the shared byte-addressed data memory.
// Accept in T, memory access in T+1, response pulse in T+2; ready is low while an access is in flight.
module datamem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 284
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [1:0]            req0_size,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [31:0]           req0_wdata,
  output logic                  req0_ready,
  output logic                  req0_rvalid,
  output logic [31:0]           req0_rdata,
  output logic                  req0_err,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [1:0]            req1_size,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [31:0]           req1_wdata,
  output logic                  req1_ready,
  output logic                  req1_rvalid,
  output logic [31:0]           req1_rdata,
  output logic                  req1_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);

  state_t                state;
  logic                  last_grant;
  logic                  sel_port;
  logic                  lat_we;
  logic [1:0]            lat_size;
  logic [1:0]            lat_off;
  logic                  lat_err;

  logic                  grant0, grant1, accept;
  logic                  cur_we;
  logic [1:0]            cur_size;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]           cur_wdata;
  logic [3:0]            cur_be;
  logic [31:0]           cur_lanes;
  logic [2:0]            bytes_m1;
  logic [ADDR_WIDTH:0]   last_byte;
  logic                  cur_err;
  logic [7:0]            load_byte;
  logic [15:0]           load_half;
  logic [31:0]           load_data;

  // Port 1 wins when alone or when port 0 was the previous grant.
  assign grant1 = req1_valid & (~req0_valid | ~last_grant);
  assign grant0 = req0_valid & ~grant1;
  assign accept = (state == IDLE) & (grant0 | grant1);

  assign req0_ready = rst_n & (state == IDLE) & grant0;
  assign req1_ready = rst_n & (state == IDLE) & grant1;

  always_comb begin
    cur_we    = grant1 ? req1_we    : req0_we;
    cur_size  = grant1 ? req1_size  : req0_size;
    cur_addr  = grant1 ? req1_addr  : req0_addr;
    cur_wdata = grant1 ? req1_wdata : req0_wdata;
    cur_be    = 4'b0000;
    cur_lanes = 32'h0;
    bytes_m1  = 3'd0;
    case (cur_size)
      2'b00: begin
        cur_be    = 4'b1000 >> cur_addr[1:0];
        cur_lanes = {4{cur_wdata[7:0]}};
        bytes_m1  = 3'd0;
      end
      2'b01: begin
        cur_be    = 4'b1100 >> cur_addr[1:0];
        cur_lanes = {2{cur_wdata[15:0]}};
        bytes_m1  = 3'd1;
      end
      2'b10: begin
        cur_be    = 4'b1111;
        cur_lanes = cur_wdata;
        bytes_m1  = 3'd3;
      end
      default: begin
        cur_be    = 4'b0000;
        cur_lanes = 32'h0;
        bytes_m1  = 3'd0;
      end
    endcase
    // One extra bit so an access running past the top of the address space still trips the range check.
    last_byte = {1'b0, cur_addr} + {{(ADDR_WIDTH-2){1'b0}}, bytes_m1};
    cur_err   = (cur_size == 2'b11)
              | ((cur_size == 2'b01) & cur_addr[0])
              | ((cur_size == 2'b10) & (cur_addr[1:0] != 2'b00))
              | (last_byte >= MEM_LIMIT);
  end

  always_comb begin
    case (lat_off)
      2'd0:    load_byte = mem_rdata[31:24];
      2'd1:    load_byte = mem_rdata[23:16];
      2'd2:    load_byte = mem_rdata[15:8];
      default: load_byte = mem_rdata[7:0];
    endcase
    load_half = lat_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    load_data = 32'h0;
    if (!lat_we && !lat_err) begin
      case (lat_size)
        2'b00:   load_data = {24'h0, load_byte};
        2'b01:   load_data = {16'h0, load_half};
        2'b10:   load_data = mem_rdata;
        default: load_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      sel_port    <= 1'b0;
      lat_we      <= 1'b0;
      lat_size    <= 2'b00;
      lat_off     <= 2'b00;
      lat_err     <= 1'b0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_be      <= 4'b0000;
      mem_wdata   <= 32'h0;
      req0_rvalid <= 1'b0;
      req0_rdata  <= 32'h0;
      req0_err    <= 1'b0;
      req1_rvalid <= 1'b0;
      req1_rdata  <= 32'h0;
      req1_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= ACCESS;
            last_grant <= grant1;
            sel_port   <= grant1;
            lat_we     <= cur_we;
            lat_size   <= cur_size;
            lat_off    <= cur_addr[1:0];
            lat_err    <= cur_err;
            mem_addr   <= {cur_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_be     <= cur_be;
            mem_wdata  <= cur_lanes;
            mem_we     <= cur_we & ~cur_err;
          end
        end
        ACCESS: begin
          state       <= RESP;
          mem_addr    <= '0;
          mem_we      <= 1'b0;
          mem_be      <= 4'b0000;
          mem_wdata   <= 32'h0;
          req0_rvalid <= ~sel_port;
          req0_rdata  <= sel_port ? 32'h0 : load_data;
          req0_err    <= ~sel_port & lat_err;
          req1_rvalid <= sel_port;
          req1_rdata  <= sel_port ? load_data : 32'h0;
          req1_err    <= sel_port & lat_err;
        end
        RESP: begin
          state       <= IDLE;
          req0_rvalid <= 1'b0;
          req0_rdata  <= 32'h0;
          req0_err    <= 1'b0;
          req1_rvalid <= 1'b0;
          req1_rdata  <= 32'h0;
          req1_err    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
// Scenario bench for datamem_arbiter with a big-endian byte memory model and a response scoreboard.
module tb_datamem_arbiter;

  localparam int MB = 284;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_we, req0_ready, req0_rvalid, req0_err;
  logic [1:0]  req0_size;
  logic [31:0] req0_addr, req0_wdata, req0_rdata;
  logic        req1_valid, req1_we, req1_ready, req1_rvalid, req1_err;
  logic [1:0]  req1_size;
  logic [31:0] req1_addr, req1_wdata, req1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [3:0]  mem_be;

  datamem_arbiter #(.ADDR_WIDTH(32), .MEM_BYTES(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_size(req0_size), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_size(req1_size), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  logic [7:0] mem [0:MB-1];
  logic [8:0] ia;
  logic       in_range;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ia       = mem_addr[8:0];
  assign in_range = ({1'b0, mem_addr} + 33'd3) < 33'(MB);

  always_comb begin
    mem_rdata = 32'h0;
    if (in_range)
      mem_rdata = {mem[ia], mem[ia + 9'd1], mem[ia + 9'd2], mem[ia + 9'd3]};
  end

  initial begin
    for (int i = 0; i < MB; i++) mem[i] <= 8'h00;
    mem[0] <= 8'h12; mem[1] <= 8'h34; mem[2]  <= 8'h56; mem[3]  <= 8'h78;
    mem[4] <= 8'hA1; mem[5] <= 8'hB2; mem[6]  <= 8'hC3; mem[7]  <= 8'hD4;
    mem[8] <= 8'h12; mem[9] <= 8'h34; mem[10] <= 8'h56; mem[11] <= 8'h78;
  end

  always @(posedge clk) begin
    if (mem_we && in_range)
      for (int i = 0; i < 4; i++)
        if (mem_be[3-i]) mem[ia + 9'(i)] <= mem_wdata[31-8*i -: 8];
  end

  // Response scoreboard: every rvalid must match the oldest outstanding expectation, two cycles after accept.
  exp_t mon_e;
  int   mon_p;
  logic [31:0] mon_d;
  logic mon_err;
  always @(negedge clk) begin
    if (req0_rvalid === 1'b1 || req1_rvalid === 1'b1) begin
      checks++;
      mon_p   = (req1_rvalid === 1'b1) ? 1 : 0;
      mon_d   = mon_p ? req1_rdata : req0_rdata;
      mon_err = mon_p ? req1_err : req0_err;
      if (req0_rvalid === 1'b1 && req1_rvalid === 1'b1) begin
        failures++;
        $display("FAIL resp_both both rvalid high at cycle %0d, required one", cyc);
      end else if (sb.size() == 0) begin
        failures++;
        $display("FAIL resp_unexpected port=%0d rdata=%h err=%b at cycle %0d, required no response", mon_p, mon_d, mon_err, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (mon_p != mon_e.port || mon_d !== mon_e.rdata || mon_err !== mon_e.err || cyc != mon_e.acc + 2) begin
          failures++;
          $display("FAIL resp got port=%0d rdata=%h err=%b cyc=%0d required port=%0d rdata=%h err=%b cyc=%0d",
                   mon_p, mon_d, mon_err, cyc, mon_e.port, mon_e.rdata, mon_e.err, mon_e.acc + 2);
        end
      end
    end
  end

  task automatic set_port(input int p, input logic v, input logic we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_size = sz; req0_addr = a; req0_wdata = wd;
    end else begin
      req1_valid = v; req1_we = we; req1_size = sz; req1_addr = a; req1_wdata = wd;
    end
  endtask

  task automatic push_exp(input int p, input logic [31:0] d, input logic e, input int acc);
    exp_t x;
    x.port = p; x.rdata = d; x.err = e; x.acc = acc;
    sb.push_back(x);
  endtask

  // Returns 1 ns after the edge that starts the ACCESS cycle.
  task automatic send(input int p, input logic we, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic push, input logic [31:0] erd, input logic eerr);
    int n;
    logic rdy;
    n = 0;
    @(negedge clk);
    set_port(p, 1'b1, we, sz, a, wd);
    #1;
    rdy = (p == 0) ? req0_ready : req1_ready;
    while (rdy !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      rdy = (p == 0) ? req0_ready : req1_ready;
      n++;
    end
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL accept_timeout port=%0d ready=%b required=1", p, rdy);
      set_port(p, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    end else begin
      if (push) push_exp(p, erd, eerr, cyc);
      @(posedge clk); #1;
      set_port(p, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL resp_timeout outstanding=%0d required=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #3;
    checks += 3;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++; $display("FAIL reset_ready got=%b required=00", {req0_ready, req1_ready});
    end
    if ({req0_rvalid, req1_rvalid, req0_err, req1_err} !== 4'b0 || req0_rdata !== 32'h0 || req1_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_resp got rv=%b%b err=%b%b rdata=%h/%h required all 0",
                           req0_rvalid, req1_rvalid, req0_err, req1_err, req0_rdata, req1_rdata);
    end
    if ({mem_addr, mem_be, mem_wdata, mem_we} !== 69'h0) begin
      failures++; $display("FAIL reset_mem got addr=%h be=%b wdata=%h we=%b required all 0", mem_addr, mem_be, mem_wdata, mem_we);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b required=1", req0_ready);
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    int prev, n, exp_p;
    logic r0, r1;
    prev = -1;
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 2'b10, 32'd0, 32'h0);
    set_port(1, 1'b1, 1'b0, 2'b10, 32'd4, 32'h0);
    for (int i = 0; i < 4; i++) begin
      exp_p = i % 2;
      n = 0;
      #1; r0 = req0_ready; r1 = req1_ready;
      while (!(r0 === 1'b1 || r1 === 1'b1) && n < 10) begin
        @(negedge clk); #1; r0 = req0_ready; r1 = req1_ready; n++;
      end
      checks++;
      if (r0 !== (exp_p == 0) || r1 !== (exp_p == 1)) begin
        failures++; $display("FAIL rr_grant iter=%0d ready0=%b ready1=%b required port %0d", i, r0, r1, exp_p);
      end
      if (prev >= 0) begin
        checks++;
        if (cyc != prev + 3) begin
          failures++; $display("FAIL rr_spacing iter=%0d accept_cycle=%0d required=%0d", i, cyc, prev + 3);
        end
      end
      prev = cyc;
      push_exp(exp_p, (exp_p == 1) ? 32'hA1B2C3D4 : 32'h12345678, 1'b0, cyc);
      @(negedge clk);
    end
    set_port(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drain();
  endtask

  task automatic test_word_load();
    send(0, 1'b0, 2'b10, 32'd8, 32'h0, 1'b1, 32'h12345678, 1'b0);
    checks += 4;
    if (mem_addr !== 32'd8) begin failures++; $display("FAIL wl_addr got=%h required=00000008", mem_addr); end
    if (mem_be !== 4'b1111) begin failures++; $display("FAIL wl_be got=%b required=1111", mem_be); end
    if (mem_we !== 1'b0) begin failures++; $display("FAIL wl_we got=%b required=0", mem_we); end
    if (req0_ready !== 1'b0) begin failures++; $display("FAIL wl_busy_ready got=%b required=0", req0_ready); end
    drain();
    checks++;
    if ({mem_addr, mem_be, mem_wdata, mem_we} !== 69'h0) begin
      failures++; $display("FAIL idle_mem got addr=%h be=%b wdata=%h we=%b required all 0", mem_addr, mem_be, mem_wdata, mem_we);
    end
  endtask

  task automatic test_byte_store_load();
    send(1, 1'b1, 2'b00, 32'd6, 32'h000000AB, 1'b1, 32'h0, 1'b0);
    checks += 4;
    if (mem_addr !== 32'd4) begin failures++; $display("FAIL bs_addr got=%h required=00000004", mem_addr); end
    if (mem_be !== 4'b0010) begin failures++; $display("FAIL bs_be got=%b required=0010", mem_be); end
    if (mem_wdata !== 32'hABABABAB) begin failures++; $display("FAIL bs_wdata got=%h required=abababab", mem_wdata); end
    if (mem_we !== 1'b1) begin failures++; $display("FAIL bs_we got=%b required=1", mem_we); end
    @(posedge clk); #1;
    checks++;
    if (mem_we !== 1'b0) begin failures++; $display("FAIL bs_we_pulse got=%b required=0", mem_we); end
    drain();
    send(1, 1'b0, 2'b00, 32'd6, 32'h0, 1'b1, 32'h000000AB, 1'b0);
    checks++;
    if (mem_be !== 4'b0010) begin failures++; $display("FAIL bl_be got=%b required=0010", mem_be); end
    drain();
  endtask

  task automatic test_errors();
    int          ep [5] = '{0, 1, 0, 0, 1};
    logic        ewe[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  esz[5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
    logic [31:0] ead[5] = '{32'd2, 32'd5, 32'd0, 32'(MB - 2), 32'hFFFFFFFE};
    for (int i = 0; i < 5; i++) begin
      send(ep[i], ewe[i], esz[i], ead[i], 32'h5555CAFE, 1'b1, 32'h0, 1'b1);
      checks++;
      if (mem_we !== 1'b0) begin failures++; $display("FAIL err_we case=%0d got=%b required=0", i, mem_we); end
      @(posedge clk); #1;
      checks++;
      if (mem_we !== 1'b0) begin failures++; $display("FAIL err_we_late case=%0d got=%b required=0", i, mem_we); end
      drain();
    end
  endtask

  task automatic test_half_load();
    send(0, 1'b0, 2'b01, 32'd2, 32'h0, 1'b1, 32'h00005678, 1'b0);
    checks += 2;
    if (mem_be !== 4'b0011) begin failures++; $display("FAIL hl_be got=%b required=0011", mem_be); end
    if (mem_addr !== 32'd0) begin failures++; $display("FAIL hl_addr got=%h required=00000000", mem_addr); end
    drain();
  endtask

  task automatic test_reset_mid_access();
    send(0, 1'b1, 2'b10, 32'd0, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    checks++;
    if (mem_we !== 1'b1) begin failures++; $display("FAIL mr_we_before got=%b required=1", mem_we); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || mem_be !== 4'b0000 || mem_addr !== 32'h0) begin
      failures++; $display("FAIL mr_async got we=%b be=%b addr=%h required 0", mem_we, mem_be, mem_addr);
    end
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    set_port(0, 1'b1, 1'b0, 2'b10, 32'd0, 32'h0);
    set_port(1, 1'b1, 1'b0, 2'b10, 32'd4, 32'h0);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++; $display("FAIL mr_first_tie ready0=%b ready1=%b required 1/0", req0_ready, req1_ready);
    end
    push_exp(0, 32'h12345678, 1'b0, cyc);
    @(posedge clk); #1;
    set_port(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_port(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    test_reset();
    test_round_robin();
    test_word_load();
    test_byte_store_load();
    test_errors();
    test_half_load();
    test_reset_mid_access();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Two-requester arbiter and access sequencer for the shared byte-addressed data memory. Port 0 is the CPU load/store path and port 1 is the test/loader port. The block accepts one request per grant and checks size, alignment and range. It drives a single word-wide memory port with big-endian byte lanes and returns the response to the granted requester two cycles after acceptance.

## Interface
Parameters:
- ADDR_WIDTH, 32, requester byte-address width
- MEM_BYTES, 284, number of addressable bytes; valid addresses are 0..MEM_BYTES-1

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- reqN_valid  in  1  (N = 0,1) request present
- reqN_we  in  1  1 = store, 0 = load
- reqN_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- reqN_addr  in  ADDR_WIDTH  byte address
- reqN_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- reqN_ready  out  1  request accepted this cycle
- reqN_rvalid  out  1  one-cycle response pulse
- reqN_rdata  out  32  load data, right-justified, zero-extended
- reqN_err  out  1  qualifies rvalid: access rejected
- mem_addr  out  ADDR_WIDTH  word-aligned address {addr[ADDR_WIDTH-1:2], 2'b00}
- mem_we  out  1  write strobe
- mem_be  out  4  byte enables; be[3] = byte at offset 0 = bits [31:24]
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  combinational big-endian word at mem_addr

## Operation
- State machine has three states: IDLE, ACCESS and RESP. Transitions: IDLE→ACCESS on accept, ACCESS→RESP always, RESP→IDLE always.
- Arbitration occurs in IDLE only.
  - If one valid is high, that port is granted.
  - If both are high, the port not granted last is granted (round-robin).
  - The last-granted register resets to 1, so port 0 wins the first tie.
- reqN_ready is combinational and high only in IDLE, for the winning port. On accept, we, size, addr, wdata and the port ID are latched.
- Requesters hold their fields stable while valid is high and ready is low. Deasserting valid before ready is legal and cancels the request.
- The error check is done on the latched fields. err = 1 if any of the following holds:
  - size = 11
  - half with addr[0] = 1
  - word with addr[1:0] ≠ 00
  - addr + bytes - 1 ≥ MEM_BYTES, computed at ADDR_WIDTH+1 bits so wrap-around cannot mask it
- Byte offset is k = addr[1:0].
  - Byte access: be = 1 << (3-k), wdata replicated in all 4 lanes, load data = mem_rdata[31-8k -: 8].
  - Half access, k ∈ {0,2}: be = 1100 >> k; load data = mem_rdata[31-8k -: 16].
  - Word access: be = 1111, no reordering.
- ACCESS cycle: mem_addr and mem_be are driven from the latched fields. mem_we = latched we & ~err. rdata is captured at the end of the cycle. Erroring requests never assert mem_we.
- RESP cycle: rvalid pulses for the latched port only, with rdata (0 for stores or errors) and err.

## Timing
- Accept in cycle T (ready high). mem_we is high in T+1 only. rvalid is high in T+2 only. The next accept is possible at T+3.
- Throughput is one access per 3 cycles. Latency is identical for errors and good accesses.
- A new valid arriving during ACCESS or RESP waits; ready stays low.
- Idle outputs: mem_addr = 0, mem_be = 0, mem_wdata = 0, mem_we = 0.
- Reset values (asynchronous on rst_n low): state IDLE, last grant = 1, all outputs 0, including ready, rvalid, rdata, err and every mem_* signal.
- Reset asserted mid-ACCESS drops mem_we immediately; no response is issued for the in-flight request.
- Leaving reset, the first active edge may accept a request.

## Test plan
- Port 0 word load at addr 8, memory bytes 8..11 = 12 34 56 78 → ready at T, mem_addr 8, mem_be 1111 at T+1, req0_rvalid at T+2 with rdata 0x12345678, err 0.
- Port 1 byte store 0xAB at addr 6 → mem_addr 4, mem_be 0010, mem_wdata 0xABABABAB, mem_we high one cycle. A following byte load from 6 returns 0x000000AB.
- Both valid in the same cycle, repeated 4 times → grants alternate 0,1,0,1. Each rvalid goes to the correct port 2 cycles after its accept.
- Error cases → err = 1, rvalid at T+2, mem_we never high:
  - word load at addr 2
  - half store at addr 5
  - size 11
  - word load at addr MEM_BYTES-2
  - addr 0xFFFFFFFE half
- Half load at addr 2 over bytes 12 34 56 78 at 0..3 → rdata 0x00005678.
- rst_n pulled low during ACCESS of a store → mem_we falls asynchronously and no rvalid appears. After release, port 0 wins the first tie.
